domain_tdm_reg_arbiter: RTL and testbench
=========================================

// Module: domain_tdm_reg_arbiter
//
// PURPOSE
//  Shares one p_nbits storage register between two requesters in different security
//  domains (0 = L, 1 = H) using fixed time-division slots.
//  A one-cycle scrub separates the slots.
//  The schedule is independent of request traffic, so neither domain can observe the
//  other's activity through timing or data.
//  Sits between domain-tagged pipeline agents and the shared register state.
//
// PARAMETERS
//  p_nbits        8   width of stored word and data ports
//  p_slot_cycles  4   cycles per domain slot; legal values are >= 2
//  p_reset_value  0   value loaded on reset and on every scrub
//
// PORTS
//  clk          in   1        clock; all state updates on the rising edge
//  reset        in   1        asynchronous, active-low (0 = in reset)
//  reqN_val     in   1        N=0,1: request valid
//  reqN_rdy     out  1        request ready; a handshake occurs when val & rdy
//  reqN_wen     in   1        1 = write wdata, 0 = read
//  reqN_wdata   in   p_nbits  write data
//  respN_val    out  1        read response valid, single-cycle pulse, no backpressure
//  respN_rdata  out  p_nbits  read data; 0 whenever respN_val = 0
//  domain       out  1        current slot owner
//  scrub        out  1        1 during scrub cycles
//
// BEHAVIOUR
//  - FSM states: SLOT0 -> SCRUB01 -> SLOT1 -> SCRUB10 -> SLOT0.
//    - Each SLOTn lasts p_slot_cycles cycles; each SCRUB state lasts 1 cycle.
//    - Period is 2*p_slot_cycles + 2 cycles.
//  - Slot counter:
//    - Width $clog2(p_slot_cycles).
//    - Counts 0..p_slot_cycles-1 in SLOTn.
//    - Cleared in SCRUB states.
//    - Advances unconditionally; the FSM never inspects val.
//  - domain output: 0 in SLOT0 and SCRUB01; 1 in SLOT1 and SCRUB10.
//  - reqN_rdy = 1 only in SLOTn with counter < p_slot_cycles-1.
//    - It is 0 in the last slot cycle, so every response lands inside the owner's slot.
//    - It is 0 for the non-owner and in both SCRUB states.
//  - Write handshake: the register takes wdata at the next edge. No response is produced.
//  - Read handshake: respN_val = 1 and respN_rdata = the register value, one cycle after
//    the handshake (latency 1).
//  - Write-then-read on back-to-back cycles returns the newly written value.
//  - The non-owner's val is ignored, not dropped. The requester holds val until its
//    slot, per the val/rdy rules.
//  - Scrub cycle:
//    - The register is loaded with p_reset_value.
//    - Both response registers are cleared.
//    - scrub = 1.
//  - Reset (asynchronous, immediate, no clock edge needed), while reset = 0:
//    - state = SLOT0, counter = 0, register = p_reset_value;
//    - respN_val = 0, respN_rdata = 0, scrub = 0, domain = 0.
//    - On release, the first cycle is SLOT0 count 0 with req0_rdy = 1.
//  - Reset during an in-flight read discards the response. No resp pulse follows release.
//  - Only the owner can hold rdy, so two requests are never both accepted in a cycle.
//
// STRUCTURE
//  - Shared package:
//    - 2-bit state encodings ST_SLOT0, ST_SCRUB01, ST_SLOT1, ST_SCRUB10;
//    - domain constants DOM_L = 0, DOM_H = 1.
//  - Sub-module domain_slot_timer:
//    - contains the counter and FSM;
//    - outputs state, domain, slot_last and scrub.
//  - Top level holds: storage register, per-domain response registers, request muxing.
//  - All flops use the asynchronous active-low reset.
//
// TESTING (p_nbits=8, p_slot_cycles=4, p_reset_value=0; cycle 0 = first edge after release)
//  1. Release reset ->
//     - cycle 0: domain=0, req0_rdy=1, req1_rdy=0, scrub=0;
//     - all resp outputs 0.
//  2. req0 write 0xA5 at cycle 0, req0 read at cycle 1 -> resp0_val=1, resp0_rdata=0xA5 at
//     cycle 2; resp1_val stays 0.
//  3. No traffic ->
//     - req0_rdy=1 for cycles 0-2 and 0 at cycle 3;
//     - scrub=1 at cycle 4;
//     - domain=1 at cycle 5; scrub=1 at cycle 9; domain=0 at cycle 10.
//  4. After test 2, req1 read at cycle 5 -> resp1_rdata=0x00 at cycle 6 (scrub erased 0xA5).
//  5. req1 read held from cycle 0 -> not accepted before cycle 5; resp1_val=1 at cycle 6.
//     Compare an idle run with a saturated run (both vals high every cycle): domain, scrub
//     and rdy waveforms must be identical.
//  6. Drive reset low mid-cycle at cycle 6, with a resp1 pulse pending ->
//     - resp1_val=0, domain=0, register=0 before the next edge;
//     - no stale pulse after release.

Source files
------------

// File: rtl/domain_tdm_reg_arbiter_pkg.sv
// Shared types for the two-domain TDM register arbiter.
// Holds the slot FSM encoding, the domain tags and the state-to-owner mapping.
package domain_tdm_reg_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_SLOT0   = 2'd0,
      ST_SCRUB01 = 2'd1,
      ST_SLOT1   = 2'd2,
      ST_SCRUB10 = 2'd3
   } slot_state_e;

   localparam logic DOM_L = 1'b0;
   localparam logic DOM_H = 1'b1;

   // A scrub cycle still belongs to the domain whose slot just ended.
   function automatic logic state_domain(input slot_state_e s);
      return (s == ST_SLOT1 || s == ST_SCRUB10) ? DOM_H : DOM_L;
   endfunction

endpackage

// File: rtl/domain_tdm_reg_arbiter_if.sv
// Request/response bundle between the two domain agents and the shared-register arbiter.
// master = agent side (drives requests), slave = arbiter side.
interface domain_tdm_reg_arbiter_if #(
   parameter int p_nbits = 8
);

   logic               req0_val;
   logic               req0_rdy;
   logic               req0_wen;
   logic [p_nbits-1:0] req0_wdata;
   logic               resp0_val;
   logic [p_nbits-1:0] resp0_rdata;

   logic               req1_val;
   logic               req1_rdy;
   logic               req1_wen;
   logic [p_nbits-1:0] req1_wdata;
   logic               resp1_val;
   logic [p_nbits-1:0] resp1_rdata;

   logic               domain;
   logic               scrub;

   modport master (
      output req0_val, req0_wen, req0_wdata,
      output req1_val, req1_wen, req1_wdata,
      input  req0_rdy, resp0_val, resp0_rdata,
      input  req1_rdy, resp1_val, resp1_rdata,
      input  domain, scrub
   );

   modport slave (
      input  req0_val, req0_wen, req0_wdata,
      input  req1_val, req1_wen, req1_wdata,
      output req0_rdy, resp0_val, resp0_rdata,
      output req1_rdy, resp1_val, resp1_rdata,
      output domain, scrub
   );

endinterface

// File: rtl/domain_tdm_reg_arbiter_domain_slot_timer.sv
// Free-running slot schedule: SLOT0 -> SCRUB01 -> SLOT1 -> SCRUB10, never looking at traffic.
// Reports the current state, owning domain, last-cycle-of-slot flag and scrub flag.
module domain_slot_timer
   import domain_tdm_reg_arbiter_pkg::*;
#(
   parameter int p_slot_cycles = 4
) (
   input  logic        clk,
   input  logic        reset,
   output slot_state_e state,
   output logic        domain,
   output logic        slot_last,
   output logic        scrub
);

   localparam int CW = (p_slot_cycles > 1) ? $clog2(p_slot_cycles) : 1;
   localparam logic [CW-1:0] LAST = CW'(p_slot_cycles - 1);

   slot_state_e   state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_SLOT0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // The counter is zero on entry to every slot because scrub states clear it.
   always_comb begin
      state_d   = state_q;
      cnt_d     = '0;
      slot_last = 1'b0;
      scrub     = 1'b0;
      case (state_q)
         ST_SLOT0: begin
            slot_last = (cnt_q == LAST);
            if (slot_last) state_d = ST_SCRUB01;
            else           cnt_d   = cnt_q + CW'(1);
         end
         ST_SCRUB01: begin
            scrub   = 1'b1;
            state_d = ST_SLOT1;
         end
         ST_SLOT1: begin
            slot_last = (cnt_q == LAST);
            if (slot_last) state_d = ST_SCRUB10;
            else           cnt_d   = cnt_q + CW'(1);
         end
         ST_SCRUB10: begin
            scrub   = 1'b1;
            state_d = ST_SLOT0;
         end
         default: state_d = ST_SLOT0;
      endcase
   end

   assign state  = state_q;
   assign domain = state_domain(state_q);

endmodule

// File: rtl/domain_tdm_reg_arbiter.sv
// One shared register time-shared between an L and an H domain agent on a fixed schedule.
// Every slot is followed by a scrub cycle that wipes the register and response state.
module domain_tdm_reg_arbiter
   import domain_tdm_reg_arbiter_pkg::*;
#(
   parameter int                 p_nbits       = 8,
   parameter int                 p_slot_cycles = 4,
   parameter logic [p_nbits-1:0] p_reset_value = '0
) (
   input logic                     clk,
   input logic                     reset,
   domain_tdm_reg_arbiter_if.slave bus
);

   slot_state_e        state;
   logic               domain;
   logic               slot_last;
   logic               scrub;

   logic               open;
   logic               rdy0, rdy1;
   logic               hs0, hs1;
   logic               rd0, rd1;
   logic               wr_en;
   logic [p_nbits-1:0] wr_data;

   logic [p_nbits-1:0] store;
   logic               resp0_val_p1, resp1_val_p1;
   logic [p_nbits-1:0] resp0_rdata_p1, resp1_rdata_p1;

   domain_slot_timer #(
      .p_slot_cycles (p_slot_cycles)
   ) u_timer (
      .clk       (clk),
      .reset     (reset),
      .state     (state),
      .domain    (domain),
      .slot_last (slot_last),
      .scrub     (scrub)
   );

   // Closing the window one cycle early keeps every read response inside its own slot.
   assign open = (state == ST_SLOT0 || state == ST_SLOT1) && !slot_last;
   assign rdy0 = open && (domain == DOM_L);
   assign rdy1 = open && (domain == DOM_H);

   assign hs0 = bus.req0_val && rdy0;
   assign hs1 = bus.req1_val && rdy1;
   assign rd0 = hs0 && !bus.req0_wen;
   assign rd1 = hs1 && !bus.req1_wen;

   always_comb begin
      wr_en   = 1'b0;
      wr_data = bus.req0_wdata;
      if (hs0 && bus.req0_wen) begin
         wr_en = 1'b1;
      end else if (hs1 && bus.req1_wen) begin
         wr_en   = 1'b1;
         wr_data = bus.req1_wdata;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         store <= p_reset_value;
      end else if (scrub) begin
         store <= p_reset_value;
      end else if (wr_en) begin
         store <= wr_data;
      end
   end

   // Response stage: one cycle after a read handshake, zeroed data when idle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         resp0_val_p1   <= 1'b0;
         resp0_rdata_p1 <= '0;
         resp1_val_p1   <= 1'b0;
         resp1_rdata_p1 <= '0;
      end else if (scrub) begin
         resp0_val_p1   <= 1'b0;
         resp0_rdata_p1 <= '0;
         resp1_val_p1   <= 1'b0;
         resp1_rdata_p1 <= '0;
      end else begin
         resp0_val_p1   <= rd0;
         resp0_rdata_p1 <= rd0 ? store : '0;
         resp1_val_p1   <= rd1;
         resp1_rdata_p1 <= rd1 ? store : '0;
      end
   end

   assign bus.req0_rdy    = rdy0;
   assign bus.req1_rdy    = rdy1;
   assign bus.resp0_val   = resp0_val_p1;
   assign bus.resp0_rdata = resp0_rdata_p1;
   assign bus.resp1_val   = resp1_val_p1;
   assign bus.resp1_rdata = resp1_rdata_p1;
   assign bus.domain      = domain;
   assign bus.scrub       = scrub;

   a_single_grant: assert property (@(posedge clk) disable iff (!reset) !(hs0 && hs1));
   a_resp0_quiet:  assert property (@(posedge clk) disable iff (!reset)
                                    !resp0_val_p1 |-> (resp0_rdata_p1 == '0));
   a_resp1_quiet:  assert property (@(posedge clk) disable iff (!reset)
                                    !resp1_val_p1 |-> (resp1_rdata_p1 == '0));
   a_no_resp_in_scrub: assert property (@(posedge clk) disable iff (!reset)
                                        scrub |-> !(resp0_val_p1 || resp1_val_p1));

endmodule

// File: tb/tb_domain_tdm_reg_arbiter.sv
// Bench for domain_tdm_reg_arbiter: directed scenarios plus random traffic against a
// schedule model computed from cycle position modulo the TDM period.
module tb_domain_tdm_reg_arbiter;

   localparam int NB  = 8;
   localparam int SC  = 4;
   localparam int PER = 2 * SC + 2;
   localparam logic [NB-1:0] RV = 8'h00;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   domain_tdm_reg_arbiter_if #(.p_nbits(NB)) bus();

   domain_tdm_reg_arbiter #(
      .p_nbits       (NB),
      .p_slot_cycles (SC),
      .p_reset_value (RV)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int cyc;

   logic          m_rv0, m_rv1;
   logic [NB-1:0] m_reg, m_rd0, m_rd1;

   logic          s_rdy0, s_rdy1, s_dom, s_scrub, s_rv0, s_rv1;
   logic [NB-1:0] s_rd0, s_rd1;
   logic          e_rdy0, e_rdy1, e_dom, e_scrub, e_rv0, e_rv1;
   logic [NB-1:0] e_rd0, e_rd1;

   logic [3:0]    idle_sig [2*PER];

   function automatic logic f_dom(input int t);
      return (t % PER) > SC;
   endfunction

   function automatic logic f_scrub(input int t);
      return ((t % PER) == SC) || ((t % PER) == PER - 1);
   endfunction

   function automatic logic f_rdy(input int n, input int t);
      int p;
      p = t % PER;
      if (n == 0) return p < SC - 1;
      return (p > SC) && (p - SC - 1 < SC - 1);
   endfunction

   task automatic model_clear();
      cyc   = 0;
      m_reg = RV;
      m_rv0 = 1'b0;
      m_rd0 = '0;
      m_rv1 = 1'b0;
      m_rd1 = '0;
   endtask

   task automatic drive_idle();
      bus.req0_val   = 1'b0;
      bus.req0_wen   = 1'b0;
      bus.req0_wdata = '0;
      bus.req1_val   = 1'b0;
      bus.req1_wen   = 1'b0;
      bus.req1_wdata = '0;
   endtask

   // Called just after a falling edge; drives one cycle, samples, steps the model.
   task automatic run_cycle(input logic v0, input logic w0, input logic [NB-1:0] d0,
                            input logic v1, input logic w1, input logic [NB-1:0] d1);
      logic h0, h1;
      bus.req0_val = v0; bus.req0_wen = w0; bus.req0_wdata = d0;
      bus.req1_val = v1; bus.req1_wen = w1; bus.req1_wdata = d1;
      #1;
      s_rdy0 = bus.req0_rdy;  s_rdy1 = bus.req1_rdy;
      s_dom  = bus.domain;    s_scrub = bus.scrub;
      s_rv0  = bus.resp0_val; s_rd0 = bus.resp0_rdata;
      s_rv1  = bus.resp1_val; s_rd1 = bus.resp1_rdata;
      e_rdy0 = f_rdy(0, cyc); e_rdy1 = f_rdy(1, cyc);
      e_dom  = f_dom(cyc);    e_scrub = f_scrub(cyc);
      e_rv0  = m_rv0; e_rd0 = m_rd0;
      e_rv1  = m_rv1; e_rd1 = m_rd1;
      h0 = v0 && e_rdy0;
      h1 = v1 && e_rdy1;
      m_rv0 = h0 && !w0;
      m_rd0 = (h0 && !w0) ? m_reg : '0;
      m_rv1 = h1 && !w1;
      m_rd1 = (h1 && !w1) ? m_reg : '0;
      if (e_scrub)       m_reg = RV;
      else if (h0 && w0) m_reg = d0;
      else if (h1 && w1) m_reg = d1;
      cyc++;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle_cycle();
      run_cycle(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
   endtask

   task automatic do_reset();
      drive_idle();
      reset = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      model_clear();
   endtask

   task automatic test_reset();
      drive_idle();
      reset = 1'b0;
      #1;
      n_cmp++;
      if ({bus.resp0_val, bus.resp1_val, bus.scrub, bus.domain} !== 4'b0000) begin
         n_bad++;
         $display("FAIL reset_ctrl: got %b required 0000",
                  {bus.resp0_val, bus.resp1_val, bus.scrub, bus.domain});
      end
      n_cmp++;
      if ({bus.resp0_rdata, bus.resp1_rdata} !== 16'h0000 || dut.store !== RV) begin
         n_bad++;
         $display("FAIL reset_data: got %h/%h/%h required 00/00/%h",
                  bus.resp0_rdata, bus.resp1_rdata, dut.store, RV);
      end
      @(negedge clk);
      reset = 1'b1;
      model_clear();
      idle_cycle();
      n_cmp++;
      if ({s_dom, s_rdy0, s_rdy1, s_scrub, s_rv0, s_rv1} !== 6'b010000) begin
         n_bad++;
         $display("FAIL cycle0: got dom/rdy0/rdy1/scrub/rv0/rv1=%b required 010000",
                  {s_dom, s_rdy0, s_rdy1, s_scrub, s_rv0, s_rv1});
      end
   endtask

   task automatic test_write_read();
      do_reset();
      run_cycle(1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, '0);
      run_cycle(1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
      idle_cycle();
      n_cmp++;
      if (s_rv0 !== 1'b1 || s_rd0 !== 8'hA5) begin
         n_bad++;
         $display("FAIL write_read: got val=%b data=%h required val=1 data=a5", s_rv0, s_rd0);
      end
      n_cmp++;
      if (s_rv1 !== 1'b0 || s_rd1 !== 8'h00) begin
         n_bad++;
         $display("FAIL write_read_other: got val=%b data=%h required 0/00", s_rv1, s_rd1);
      end
   endtask

   task automatic test_schedule();
      do_reset();
      for (int t = 0; t < 2 * PER; t++) begin
         idle_cycle();
         idle_sig[t] = {s_dom, s_scrub, s_rdy0, s_rdy1};
         n_cmp++;
         if ({s_dom, s_scrub, s_rdy0, s_rdy1} !== {e_dom, e_scrub, e_rdy0, e_rdy1}) begin
            n_bad++;
            $display("FAIL schedule c%0d: got %b required %b", t,
                     {s_dom, s_scrub, s_rdy0, s_rdy1}, {e_dom, e_scrub, e_rdy0, e_rdy1});
         end
      end
      n_cmp++;
      if (idle_sig[3] !== 4'b0000 || idle_sig[4] !== 4'b0100 || idle_sig[5] !== 4'b1001 ||
          idle_sig[9] !== 4'b1100 || idle_sig[10] !== 4'b0010) begin
         n_bad++;
         $display("FAIL schedule_points: got %b %b %b %b %b required 0000 0100 1001 1100 0010",
                  idle_sig[3], idle_sig[4], idle_sig[5], idle_sig[9], idle_sig[10]);
      end
   endtask

   task automatic test_saturated();
      logic          w0, w1;
      logic [NB-1:0] d0, d1;
      do_reset();
      for (int t = 0; t < 2 * PER; t++) begin
         w0 = 1'($urandom_range(0, 1));
         w1 = 1'($urandom_range(0, 1));
         d0 = 8'($urandom_range(0, 255));
         d1 = 8'($urandom_range(0, 255));
         run_cycle(1'b1, w0, d0, 1'b1, w1, d1);
         n_cmp++;
         if ({s_dom, s_scrub, s_rdy0, s_rdy1} !== idle_sig[t]) begin
            n_bad++;
            $display("FAIL saturated_vs_idle c%0d: got %b required %b", t,
                     {s_dom, s_scrub, s_rdy0, s_rdy1}, idle_sig[t]);
         end
         n_cmp++;
         if ({s_rv0, s_rd0, s_rv1, s_rd1} !== {e_rv0, e_rd0, e_rv1, e_rd1}) begin
            n_bad++;
            $display("FAIL saturated_resp c%0d: got %b/%h %b/%h required %b/%h %b/%h", t,
                     s_rv0, s_rd0, s_rv1, s_rd1, e_rv0, e_rd0, e_rv1, e_rd1);
         end
      end
   endtask

   task automatic test_scrub_erase();
      do_reset();
      run_cycle(1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, '0);
      run_cycle(1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
      for (int t = 2; t < 5; t++) idle_cycle();
      run_cycle(1'b0, 1'b0, '0, 1'b1, 1'b0, '0);
      idle_cycle();
      n_cmp++;
      if (s_rv1 !== 1'b1 || s_rd1 !== 8'h00) begin
         n_bad++;
         $display("FAIL scrub_erase: got val=%b data=%h required val=1 data=00", s_rv1, s_rd1);
      end
   endtask

   task automatic test_held_request();
      int  acc;
      logic pend;
      do_reset();
      acc  = -1;
      pend = 1'b1;
      for (int t = 0; t < 3 * PER && pend; t++) begin
         run_cycle(1'b0, 1'b0, '0, 1'b1, 1'b0, '0);
         if (s_rdy1) begin
            acc  = t;
            pend = 1'b0;
         end
      end
      n_cmp++;
      if (acc != SC + 1) begin
         n_bad++;
         $display("FAIL held_accept: got cycle %0d required %0d", acc, SC + 1);
      end
      idle_cycle();
      n_cmp++;
      if (s_rv1 !== 1'b1 || s_rv0 !== 1'b0) begin
         n_bad++;
         $display("FAIL held_resp: got rv1=%b rv0=%b required 1/0", s_rv1, s_rv0);
      end
   endtask

   task automatic test_reset_inflight();
      do_reset();
      for (int t = 0; t < 5; t++) idle_cycle();
      run_cycle(1'b0, 1'b0, '0, 1'b1, 1'b0, '0);
      drive_idle();
      #1;
      n_cmp++;
      if (bus.resp1_val !== 1'b1) begin
         n_bad++;
         $display("FAIL pending_pulse: got %b required 1", bus.resp1_val);
      end
      #2 reset = 1'b0;
      #1;
      n_cmp++;
      if (bus.resp1_val !== 1'b0 || bus.domain !== 1'b0 || dut.store !== RV) begin
         n_bad++;
         $display("FAIL mid_reset: got rv1=%b dom=%b reg=%h required 0/0/%h",
                  bus.resp1_val, bus.domain, dut.store, RV);
      end
      @(negedge clk);
      reset = 1'b1;
      model_clear();
      // In-flight read: write at cycle 5, read at cycle 6, reset before its response.
      for (int t = 0; t < 5; t++) idle_cycle();
      run_cycle(1'b0, 1'b0, '0, 1'b1, 1'b1, 8'h3C);
      bus.req1_val = 1'b1; bus.req1_wen = 1'b0;
      #1 reset = 1'b0;
      #1;
      n_cmp++;
      if (dut.store !== RV || bus.resp1_val !== 1'b0) begin
         n_bad++;
         $display("FAIL inflight_reset: got reg=%h rv1=%b required %h/0",
                  dut.store, bus.resp1_val, RV);
      end
      @(negedge clk);
      reset = 1'b1;
      model_clear();
      for (int t = 0; t < 4; t++) begin
         idle_cycle();
         n_cmp++;
         if (s_rv0 !== 1'b0 || s_rv1 !== 1'b0 || s_dom !== e_dom) begin
            n_bad++;
            $display("FAIL stale_pulse c%0d: got rv0=%b rv1=%b dom=%b required 0/0/%b",
                     t, s_rv0, s_rv1, s_dom, e_dom);
         end
      end
   endtask

   task automatic test_random();
      logic          v0, w0, v1, w1;
      logic [NB-1:0] d0, d1;
      do_reset();
      for (int t = 0; t < 8 * PER; t++) begin
         v0 = 1'($urandom_range(0, 1)); w0 = 1'($urandom_range(0, 1));
         v1 = 1'($urandom_range(0, 1)); w1 = 1'($urandom_range(0, 1));
         d0 = 8'($urandom_range(0, 255));
         d1 = 8'($urandom_range(0, 255));
         run_cycle(v0, w0, d0, v1, w1, d1);
         n_cmp++;
         if ({s_dom, s_scrub, s_rdy0, s_rdy1} !== {e_dom, e_scrub, e_rdy0, e_rdy1}) begin
            n_bad++;
            $display("FAIL random_ctrl c%0d: got %b required %b", t,
                     {s_dom, s_scrub, s_rdy0, s_rdy1}, {e_dom, e_scrub, e_rdy0, e_rdy1});
         end
         n_cmp++;
         if ({s_rv0, s_rd0} !== {e_rv0, e_rd0}) begin
            n_bad++;
            $display("FAIL random_resp0 c%0d: got %b/%h required %b/%h",
                     t, s_rv0, s_rd0, e_rv0, e_rd0);
         end
         n_cmp++;
         if ({s_rv1, s_rd1} !== {e_rv1, e_rd1}) begin
            n_bad++;
            $display("FAIL random_resp1 c%0d: got %b/%h required %b/%h",
                     t, s_rv1, s_rd1, e_rv1, e_rd1);
         end
      end
   endtask

   initial begin
      drive_idle();
      model_clear();
      @(negedge clk);
      test_reset();
      test_write_read();
      test_schedule();
      test_saturated();
      test_scrub_erase();
      test_held_request();
      test_reset_inflight();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
